// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: instruction sequencer / decoder for the SIAA accumulator ALU.
//
// Fetches 9-bit instructions, holds them in ir, and exposes the ALU control
// fields straight from ir. It also issues the accumulator, register-file and
// data-memory strobes, and moves the PC using the ALU branch flag.
//
// Ports
//   clk, rst_n       rising-edge clock, async active-low reset
//   start            begin/restart at PC 0 (honoured only in IDLE/HALT)
//   instr_req/addr   fetch handshake out; instr_ack/instr in
//   type_code..      decode fields (0 in IDLE, otherwise sliced from ir)
//   alu_branch       branch-taken flag from the ALU
//   branch_tgt       jump target
//   acc_we, reg_we   single-cycle write strobes
//   mem_req/mem_we   data-memory request; mem_ack completes it
//   done             sticky halt flag
//   pc               current PC
//   retired          saturating count of completed instructions
module alu_ctrl_seq #(
  parameter int PCW  = 10,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            instr_req,
  output logic [PCW-1:0]  instr_addr,
  input  logic            instr_ack,
  input  logic [8:0]      instr,
  output logic            type_code,
  output logic [3:0]      r_op,
  output logic [2:0]      i_op,
  output logic [4:0]      imm,
  output logic [3:0]      reg_sel,
  input  logic            alu_branch,
  input  logic [PCW-1:0]  branch_tgt,
  output logic            acc_we,
  output logic            reg_we,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ack,
  output logic            done,
  output logic [PCW-1:0]  pc,
  output logic [CNTW-1:0] retired
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_BR  = 4'b1100;
  localparam logic [3:0] OP_J   = 4'b1101;
  localparam logic [3:0] OP_SET = 4'b1110;

  state_t          state, stateNext;
  logic [8:0]      ir, irNext, irVis;
  logic [PCW-1:0]  pcNext, pcInc;
  logic [CNTW-1:0] retiredNext;
  logic            doneNext;
  logic            retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
      done    <= 1'b0;
    end else begin
      state   <= stateNext;
      pc      <= pcNext;
      ir      <= irNext;
      retired <= retiredNext;
      done    <= doneNext;
    end
  end

  // Decode fields track ir everywhere except IDLE, so they stay stable
  // through EXEC/MEM and show the previous instruction during FETCH.
  assign irVis     = (state == IDLE) ? 9'd0 : ir;
  assign type_code = irVis[8];
  assign r_op      = irVis[7:4];
  assign i_op      = irVis[7:5];
  assign imm       = irVis[4:0];
  assign reg_sel   = irVis[3:0];

  assign instr_addr = pc;
  assign pcInc      = pc + PCW'(1);   // natural wrap at 2^PCW

  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    irNext      = ir;
    doneNext    = done;
    retiredNext = retired;
    retire      = 1'b0;
    instr_req   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    acc_we      = 1'b0;
    reg_we      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          pcNext      = '0;
          retiredNext = '0;
          stateNext   = FETCH;
        end
      end

      FETCH: begin
        instr_req = 1'b1;
        if (instr_ack) begin
          irNext    = instr;
          stateNext = EXEC;
        end
      end

      EXEC: begin
        // Most instructions complete here and fall through to the next PC;
        // the cases below only override what differs.
        retire    = 1'b1;
        pcNext    = pcInc;
        stateNext = FETCH;
        if (!ir[8]) begin
          case (ir[7:4])
            OP_SET: reg_we = 1'b1;
            OP_LW, OP_SW: begin
              retire    = 1'b0;   // counted on mem_ack instead
              pcNext    = pc;
              stateNext = MEM;
            end
            OP_BR:   pcNext = alu_branch ? branch_tgt : pcInc;
            OP_J:    pcNext = branch_tgt;
            default: acc_we = 1'b1;
          endcase
        end else begin
          case (ir[7:5])
            3'b110: ;             // NOP
            3'b111: begin
              if (ir[4:0] == 5'b11111) begin
                pcNext    = pc;
                doneNext  = 1'b1;
                stateNext = HALT;
              end
            end
            default: acc_we = 1'b1;
          endcase
        end
      end

      MEM: begin
        mem_req = 1'b1;
        mem_we  = (ir[7:4] == OP_SW);
        if (mem_ack) begin
          acc_we    = (ir[7:4] == OP_LW);
          retire    = 1'b1;
          pcNext    = pcInc;
          stateNext = FETCH;
        end
      end

      HALT: begin
        if (start) begin
          doneNext    = 1'b0;
          pcNext      = '0;
          retiredNext = '0;
          stateNext   = FETCH;
        end
      end

      default: stateNext = IDLE;
    endcase

    if (retire && (retired != {CNTW{1'b1}}))
      retiredNext = retired + CNTW'(1);
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq. The bench acts as instruction and
// data memory. An instruction-level model predicts the strobes, the PC,
// the retired count and the done flag for every instruction it feeds in.
module tb_alu_ctrl_seq;
  localparam int PCW  = 10;
  localparam int CNTW = 4;    // small counter so saturation is reachable

  localparam int K_ALU = 0, K_SET = 1, K_LW = 2, K_SW = 3,
                 K_BR  = 4, K_J   = 5, K_NOP = 6, K_HALT = 7;

  logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic            instr_req, instr_ack = 1'b0;
  logic [PCW-1:0]  instr_addr, branch_tgt = '0, pc;
  logic [8:0]      instr = '0;
  logic            type_code, acc_we, reg_we, mem_req, mem_we, done;
  logic [3:0]      r_op, reg_sel;
  logic [2:0]      i_op;
  logic [4:0]      imm;
  logic            alu_branch = 1'b0, mem_ack = 1'b0;
  logic [CNTW-1:0] retired;

  int checks = 0, failures = 0;
  int mPc = 0, mRet = 0;
  bit mDone = 0;
  logic [8:0] prevWord = '0;
  logic [8:0] w;

  alu_ctrl_seq #(.PCW(PCW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack),
    .instr(instr), .type_code(type_code), .r_op(r_op), .i_op(i_op),
    .imm(imm), .reg_sel(reg_sel), .alu_branch(alu_branch),
    .branch_tgt(branch_tgt), .acc_we(acc_we), .reg_we(reg_we),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack), .done(done),
    .pc(pc), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int kindOf(input logic [8:0] x);
    int op;
    if (x[8] == 1'b0) begin
      op = int'(x[7:4]);
      if (op == 14) return K_SET;
      if (op == 8)  return K_LW;
      if (op == 9)  return K_SW;
      if (op == 12) return K_BR;
      if (op == 13) return K_J;
      return K_ALU;
    end
    op = int'(x[7:5]);
    if (op == 6) return K_NOP;
    if (op == 7) return (x[4:0] == 5'd31) ? K_HALT : K_NOP;
    return K_ALU;
  endfunction

  task automatic chkQuiet(input string tag);
    chk({tag, "_req"},  32'(instr_req), 0);
    chk({tag, "_acc"},  32'(acc_we), 0);
    chk({tag, "_reg"},  32'(reg_we), 0);
    chk({tag, "_mreq"}, 32'(mem_req), 0);
    chk({tag, "_mwe"},  32'(mem_we), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pc"},   32'(pc), 0);
    chk({tag, "_ret"},  32'(retired), 0);
    chk({tag, "_dec"},  32'({type_code, r_op, i_op, imm, reg_sel}), 0);
  endtask

  task automatic startPulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mPc = 0; mRet = 0; mDone = 0;
    chk("start_done", 32'(done), 0);
    chk("start_req",  32'(instr_req), 1);
    chk("start_addr", 32'(instr_addr), 0);
    chk("start_ret",  32'(retired), 0);
  endtask

  // Feed one instruction starting from FETCH and check it end to end.
  task automatic runInstr(input logic [8:0] x, input int ackDly, input int memDly,
                          input logic br, input logic [PCW-1:0] tgt, input bit abortMem);
    int k, nxt;
    k = kindOf(x);
    for (int i = 0; i <= ackDly; i++) begin
      chk("fetch_req",  32'(instr_req), 1);
      chk("fetch_addr", 32'(instr_addr), 32'(mPc));
      chk("fetch_hold", 32'({r_op, imm}), 32'({prevWord[7:4], prevWord[4:0]}));
      chk("fetch_strb", 32'({acc_we, reg_we, mem_req}), 0);
      if (i < ackDly) begin
        instr_ack = 1'b0;
        start     = 1'($urandom_range(0, 1));   // ignored in FETCH
        mem_ack   = 1'($urandom_range(0, 1));   // ignored outside MEM
        instr     = 9'($urandom);
        @(posedge clk); #1;
      end
    end
    start = 1'b0; mem_ack = 1'b0;
    instr_ack = 1'b1; instr = x; alu_branch = br; branch_tgt = tgt;
    @(posedge clk); #1;
    instr_ack = 1'($urandom_range(0, 1));        // ignored in EXEC
    instr     = 9'($urandom);
    start     = 1'($urandom_range(0, 1));        // ignored in EXEC

    chk("exec_type", 32'(type_code), 32'(x[8]));
    chk("exec_rop",  32'(r_op), 32'(x[7:4]));
    chk("exec_iop",  32'(i_op), 32'(x[7:5]));
    chk("exec_imm",  32'(imm), 32'(x[4:0]));
    chk("exec_rsel", 32'(reg_sel), 32'(x[3:0]));
    chk("exec_acc",  32'(acc_we), 32'(k == K_ALU));
    chk("exec_reg",  32'(reg_we), 32'(k == K_SET));
    chk("exec_mreq", 32'(mem_req), 0);
    chk("exec_req",  32'(instr_req), 0);

    case (k)
      K_BR:    nxt = br ? int'(tgt) : (mPc + 1) % 1024;
      K_J:     nxt = int'(tgt);
      K_HALT:  nxt = mPc;
      default: nxt = (mPc + 1) % 1024;
    endcase

    @(posedge clk); #1;
    instr_ack = 1'b0; start = 1'b0;
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i <= memDly; i++) begin
        chk("mem_req",  32'(mem_req), 1);
        chk("mem_we",   32'(mem_we), 32'(k == K_SW));
        chk("mem_rsel", 32'(reg_sel), 32'(x[3:0]));
        chk("mem_acc",  32'(acc_we), 0);
        chk("mem_pc",   32'(pc), 32'(mPc));
        if (i < memDly) begin
          mem_ack = 1'b0;
          @(posedge clk); #1;
        end
      end
      mem_ack = 1'b1; #1;
      if (abortMem) begin
        rst_n = 1'b0; #1;
        chkQuiet("abort");
        mem_ack = 1'b0;
        mPc = 0; mRet = 0; mDone = 0; prevWord = '0;
        return;
      end
      chk("memack_acc", 32'(acc_we), 32'(k == K_LW));
      chk("memack_reg", 32'(reg_we), 0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    mPc = nxt;
    if (mRet < 15) mRet++;
    if (k == K_HALT) mDone = 1;
    prevWord = x;
    chk("post_pc",   32'(pc), 32'(mPc));
    chk("post_ret",  32'(retired), 32'(mRet));
    chk("post_done", 32'(done), 32'(mDone));
    chk("post_strb", 32'({acc_we, reg_we}), 0);
  endtask

  initial begin
    // Reset state
    #12;
    chkQuiet("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_req", 32'(instr_req), 0);

    // ADDI 5 then HALT, ack always immediate
    startPulse();
    runInstr(9'h105, 0, 0, 1'b0, '0, 0);
    runInstr(9'h1FF, 0, 0, 1'b0, '0, 0);
    chk("halt_pc", 32'(pc), 1);
    chk("halt_ret", 32'(retired), 2);
    instr_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    instr_ack = 1'b0;
    chk("halt_sticky", 32'(done), 1);
    chk("halt_noreq", 32'(instr_req), 0);

    // Restart after HALT, then LW/SW with slow memory
    startPulse();
    runInstr(9'h083, 1, 3, 1'b0, '0, 0);
    runInstr(9'h093, 0, 3, 1'b0, '0, 0);
    runInstr(9'h1C0, 0, 0, 1'b0, '0, 0);
    runInstr(9'h1C0, 2, 0, 1'b0, '0, 0);
    // BR/J around pc 4 with target 20
    runInstr(9'h0C2, 0, 0, 1'b1, 10'd20, 0);
    runInstr(9'h0D2, 0, 0, 1'b0, 10'd4, 0);
    runInstr(9'h0C2, 0, 0, 1'b0, 10'd20, 0);
    runInstr(9'h0D2, 0, 0, 1'b0, 10'd20, 0);
    runInstr(9'h0D2, 1, 0, 1'b1, 10'd20, 0);   // jump to itself
    runInstr(9'h0E1, 0, 0, 1'b0, '0, 0);       // SET
    runInstr(9'h1E0, 0, 0, 1'b0, '0, 0);       // I 111 non-halt NOP
    // Wrap from 1023 to 0
    runInstr(9'h0D2, 0, 0, 1'b0, 10'd1023, 0);
    runInstr(9'h1C0, 0, 0, 1'b0, '0, 0);
    chk("wrap_addr", 32'(instr_addr), 0);

    // Random programme; retired saturates along the way
    for (int n = 0; n < 60; n++) begin
      if (mDone) startPulse();
      w = 9'($urandom);
      runInstr(w, $urandom_range(0, 2), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 0);
    end

    // Reset while MEM has mem_ack pending
    if (mDone) startPulse();
    runInstr(9'h083, 0, 1, 1'b0, '0, 1);
    @(posedge clk); #3;
    chkQuiet("abort_hold");
    rst_n = 1'b1;
    instr_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    instr_ack = 1'b0;
    chk("abort_idle_req", 32'(instr_req), 0);
    chk("abort_idle_pc",  32'(pc), 0);
    startPulse();
    runInstr(9'h105, 0, 0, 1'b0, '0, 0);
    runInstr(9'h1FF, 1, 0, 1'b0, '0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
